// File: rtl/top2_frame_ctrl.sv
// ---------------------------------------------------------------------------
// top2_frame_ctrl
//
// Purpose:
//    Frame-based running top-two tracker. Incoming samples are grouped into
//    frames of up to FRAME_LEN samples. A frame also closes early on an
//    accepted beat with s_last set. For each frame the largest value, the
//    second-largest value and the sample count are presented on a
//    valid/ready result port. The sample port is stalled while a result
//    is waiting for the consumer.
//
// Ports:
//    clk      in   1       rising-edge clock
//    reset    in   1       synchronous active-high reset
//    s_valid  in   1       input sample valid
//    s_ready  out  1       controller can accept a sample
//    s_data   in   DATA_W  unsigned sample value
//    s_last   in   1       accepted sample closes the current frame early
//    m_valid  out  1       frame result valid
//    m_ready  in   1       consumer accepts the result
//    m_max1   out  DATA_W  largest sample of the frame
//    m_max2   out  DATA_W  second-largest sample of the frame
//    m_count  out  CNT_W   number of samples in the frame
//
// Configuration macro:
//    TOP2_DISTINCT_EN  when defined, max2 tracks the largest value strictly
//                      below max1, so a repeat of max1 does not touch max2.
//                      When undefined, a repeat of max1 may set max2.
// ---------------------------------------------------------------------------
module top2_frame_ctrl #(
    parameter  int DATA_W    = 32,
    parameter  int FRAME_LEN = 8,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_max1,
    output logic [DATA_W-1:0] m_max2,
    output logic [CNT_W-1:0]  m_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Count value seen just before the beat that fills the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   max1_q, max1_d;
    logic [DATA_W-1:0]   max2_q, max2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                take;
    logic                closeFrame;

    // Registered state. Reset discards any partial frame or pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            max1_q  <= '0;
            max2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            max1_q  <= max1_d;
            max2_q  <= max2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign take       = (state_q == ACCUM) && s_valid;
    // s_last on the filling beat still closes just one frame, since both
    // conditions lead to the same single transition.
    assign closeFrame = s_last || (cnt_q == LAST_CNT);

    // Next-state logic: the tracker compares against the registered maxima,
    // so the closing sample is already folded in when HOLD is entered.
    always_comb begin
        state_d = state_q;
        max1_d  = max1_q;
        max2_d  = max2_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACCUM: begin
                if (take) begin
                    cnt_d = cnt_q + 1'b1;
                    if (s_data > max1_q) begin
                        max2_d = max1_q;
                        max1_d = s_data;
`ifdef TOP2_DISTINCT_EN
                    end else if ((s_data != max1_q) && (s_data > max2_q)) begin
`else
                    end else if (s_data > max2_q) begin
`endif
                        max2_d = s_data;
                    end
                    if (closeFrame) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // The tracker is cleared on the handshake, so s_ready comes
                // back one cycle later, giving one bubble per frame.
                if (m_ready) begin
                    max1_d  = '0;
                    max2_d  = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign s_ready = (state_q == ACCUM);
    assign m_valid = (state_q == HOLD);
    assign m_max1  = max1_q;
    assign m_max2  = max2_q;
    assign m_count = cnt_q;

endmodule

// File: tb/tb_top2_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_top2_frame_ctrl
//
// Purpose:
//    Self-checking bench for top2_frame_ctrl with FRAME_LEN=4. Each frame
//    that should produce a result pushes a reference result into a queue.
//    A monitor pops it whenever the DUT completes a result handshake.
//    Reset behaviour, backpressure stability and bubble timing are checked
//    directly against fixed values.
// ---------------------------------------------------------------------------
module tb_top2_frame_ctrl;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    typedef struct {
        logic [DATA_W-1:0] max1;
        logic [DATA_W-1:0] max2;
        logic [CNT_W-1:0]  count;
    } result_t;

    logic              clk;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_max1;
    logic [DATA_W-1:0] m_max2;
    logic [CNT_W-1:0]  m_count;

    result_t expQ[$];
    int      assertCount = 0;
    int      failCount   = 0;
    int      pushedCount = 0;
    int      poppedCount = 0;

    top2_frame_ctrl #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_max1  (m_max1),
        .m_max2  (m_max2),
        .m_count (m_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference result: max1 is the overall maximum. Without the distinct
    // option, max2 is the largest value left after removing one copy of
    // max1. With it, max2 is the largest value strictly below max1.
    function automatic result_t refModel(input logic [DATA_W-1:0] v[$]);
        result_t r;
        bit      removed;
        r.max1  = '0;
        r.max2  = '0;
        r.count = CNT_W'(v.size());
        foreach (v[i]) if (v[i] > r.max1) r.max1 = v[i];
        removed = 1'b0;
        foreach (v[i]) begin
`ifdef TOP2_DISTINCT_EN
            if (v[i] < r.max1 && v[i] > r.max2) r.max2 = v[i];
`else
            if (!removed && v[i] == r.max1) removed = 1'b1;
            else if (v[i] > r.max2) r.max2 = v[i];
`endif
        end
        return r;
    endfunction

    // Scoreboard monitor: a result is consumed when valid and ready are both
    // high. This is sampled mid-cycle, so the inputs are already settled.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                result_t e;
                e = expQ.pop_front();
                poppedCount++;
                checkOutput("sb_max1", 64'(m_max1), 64'(e.max1));
                checkOutput("sb_max2", 64'(m_max2), 64'(e.max2));
                checkOutput("sb_count", 64'(m_count), 64'(e.count));
            end
        end
    end

    // Drives one beat and waits, within a bounded time, until it is accepted.
    // Returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic last);
        int waitCnt;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        waitCnt = 0;
        while (!s_ready && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!s_ready) checkOutput("sready_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Sends a whole frame. s_last is placed on the final beat if requested.
    // The reference result is pushed only when a result is expected.
    task automatic sendFrame(input logic [DATA_W-1:0] v[$], input bit lastOnEnd,
                             input bit expectResult);
        if (expectResult) begin
            expQ.push_back(refModel(v));
            pushedCount++;
        end
        foreach (v[i]) applyStimulus(v[i], lastOnEnd && (i == v.size() - 1));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [DATA_W-1:0] frame[$];
        int                waitCnt;
        int                len;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        tick(3);

        // Reset state
        checkOutput("rst_s_ready", 64'(s_ready), 1);
        checkOutput("rst_m_valid", 64'(m_valid), 0);
        checkOutput("rst_m_max1", 64'(m_max1), 0);
        checkOutput("rst_m_max2", 64'(m_max2), 0);
        checkOutput("rst_m_count", 64'(m_count), 0);
        reset = 1'b0;
        tick(1);

        // Full-length frame with the consumer stalled
        frame = '{32'd5, 32'd9, 32'd3, 32'd7};
        sendFrame(frame, 1'b0, 1'b1);
        checkOutput("lat_m_valid", 64'(m_valid), 1);
        checkOutput("lat_s_ready", 64'(s_ready), 0);
        s_valid = 1'b1;
        s_data  = 32'd99;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_max1", 64'(m_max1), 9);
            checkOutput("bp_max2", 64'(m_max2), 7);
            checkOutput("bp_count", 64'(m_count), 4);
            checkOutput("bp_s_ready", 64'(s_ready), 0);
            checkOutput("bp_m_valid", 64'(m_valid), 1);
            tick(1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick(1);
        checkOutput("bubble_s_ready", 64'(s_ready), 1);
        checkOutput("bubble_m_valid", 64'(m_valid), 0);
        checkOutput("bubble_count", 64'(m_count), 0);

        // Early close with s_last, then a single-sample frame
        frame = '{32'd4, 32'd2};
        sendFrame(frame, 1'b1, 1'b1);
        frame = '{32'd11};
        sendFrame(frame, 1'b1, 1'b1);

        // Duplicates of the maximum
        frame = '{32'd6, 32'd6, 32'd1, 32'd2};
        sendFrame(frame, 1'b0, 1'b1);

        // s_last on the filling beat must close exactly one frame
        frame = '{32'd3, 32'd1, 32'd8, 32'd5};
        sendFrame(frame, 1'b1, 1'b1);

        // s_last while idle is ignored
        tick(2);
        applyStimulus(32'd20, 1'b0);
        s_last = 1'b1;
        tick(2);
        s_last = 1'b0;
        expQ.push_back(refModel('{32'd20, 32'd30}));
        pushedCount++;
        applyStimulus(32'd30, 1'b1);

        // Reset mid-frame discards the partial frame
        tick(2);
        applyStimulus(32'd100, 1'b0);
        applyStimulus(32'd50, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("midrst_count", 64'(m_count), 0);
        frame = '{32'd1, 32'd2, 32'd3, 32'd4};
        sendFrame(frame, 1'b0, 1'b1);

        // Reset while holding a result drops it
        tick(2);
        m_ready = 1'b0;
        frame = '{32'd40, 32'd41};
        sendFrame(frame, 1'b1, 1'b0);
        checkOutput("hold_m_valid", 64'(m_valid), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("holdrst_m_valid", 64'(m_valid), 0);
        checkOutput("holdrst_s_ready", 64'(s_ready), 1);
        m_ready = 1'b1;
        frame = '{32'd8, 32'd8, 32'd8, 32'd8};
        sendFrame(frame, 1'b0, 1'b1);

        // Random frames over a narrow value range to provoke ties
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, FRAME_LEN);
            frame.delete();
            for (int i = 0; i < len; i++) frame.push_back(DATA_W'($urandom_range(0, 7)));
            sendFrame(frame, (len < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
        end

        // Let the scoreboard drain, within a bounded time
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 100) begin
            tick(1);
            waitCnt++;
        end
        tick(3);
        checkOutput("sb_drain", 64'(expQ.size()), 0);
        checkOutput("frame_total", 64'(poppedCount), 64'(pushedCount));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/top2_frame_ctrl.md
Name: top2_frame_ctrl

Overview:
- Frame-based controller for a running top-two (largest / second-largest) tracker.
- Accepts a valid/ready sample stream and splits it into frames of FRAME_LEN samples, or shorter when s_last is asserted.
- Clears the tracker at each frame boundary and presents max1/max2/count per frame on a valid/ready result port.
- Sits between a sample source and a result consumer; applies backpressure while a result is pending.

Parameters:
- DATA_W, 32, sample width, unsigned.
- FRAME_LEN, 8, maximum samples per frame, >= 1.
- CNT_W (localparam), $clog2(FRAME_LEN+1), width of the sample counter and m_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller can accept a sample.
- s_data  in  DATA_W  sample value, unsigned.
- s_last  in  1  accepted sample closes the current frame early.
- m_valid  out  1  frame result valid.
- m_ready  in  1  consumer accepts the result.
- m_max1  out  DATA_W  largest sample in the frame.
- m_max2  out  DATA_W  second-largest sample in the frame.
- m_count  out  CNT_W  number of samples in the frame, 1..FRAME_LEN.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high, sampled on the rising clk edge, with priority over all other activity.
- Reset values: state=ACCUM, s_ready=1, m_valid=0, m_max1=0, m_max2=0, m_count=0.
- FSM has two states:
  - ACCUM: s_ready=1, m_valid=0.
  - HOLD: s_ready=0, m_valid=1.
- ACCUM, sample accepted (s_valid && s_ready):
  - count <= count+1.
  - Tracker update uses registered max1/max2 from before the edge, unsigned compare:
    - if s_data > max1: max2 <= max1, max1 <= s_data;
    - else if s_data > max2: max2 <= s_data;
    - else no change.
  - Equal-to-max1 samples fall into the second branch and may set max2 (duplicates count; see macro).
- Frame close: when the accepted beat has s_last=1 or count==FRAME_LEN-1, go to HOLD on the same edge. The registered outputs then already include that closing sample.
- Latency: m_valid rises the cycle after the closing beat is accepted.
- HOLD:
  - m_max1, m_max2 and m_count are stable until the handshake completes.
  - s_valid is ignored; no sample is consumed.
  - On m_valid && m_ready: max1=max2=0, count=0, return to ACCUM. s_ready rises the next cycle, giving one bubble cycle per frame.
- Outputs in ACCUM: m_max1/m_max2/m_count show the live partial values. They are don't-care to the consumer because m_valid=0.
- Frame with one sample: max2=0, count=1.
- FRAME_LEN=1: every sample forms its own frame.
- s_last on a beat where count==FRAME_LEN-1 closes the frame once, with no empty extra frame.
- s_last while s_valid=0: ignored.
- Reset mid-frame: the partial frame is discarded and no result is emitted.
- Reset in HOLD: the pending result is dropped and m_valid=0 on the next cycle.
- Counter never wraps; count never exceeds FRAME_LEN.

Optional Feature:
- Macro: TOP2_DISTINCT_EN.
- Defined: max2 tracks the largest value strictly less than max1. A sample equal to max1 is ignored by the tracker but still increments count. When max1 is replaced, max2 takes the old max1 as usual.
- Undefined: duplicate behaviour as stated in Behaviour (a sample equal to max1 may set max2).

Test Plan:
- FRAME_LEN=4, samples 5,9,3,7 back-to-back with s_last=0 -> one cycle after the 4th beat: m_valid=1, m_max1=9, m_max2=7, m_count=4; s_ready=0 until m_ready.
- Samples 4,2 with s_last=1 on 2 -> m_max1=4, m_max2=2, m_count=2. Then single sample 11 with s_last=1 -> 11, 0, 1 (tracker was cleared between frames).
- Backpressure: hold m_ready=0 for 3 cycles in HOLD while s_valid=1 -> outputs stable, s_ready=0, no sample consumed. m_ready=1 -> s_ready=1 on the next cycle.
- Duplicates 6,6,1,2 (FRAME_LEN=4) -> macro undefined: max1=6, max2=6. Macro defined: max1=6, max2=2. m_count=4 in both cases.
- Reset for 1 cycle after accepting 100,50 -> no result emitted. Next frame 1,2,3,4 -> m_max1=4, m_max2=3, m_count=4.
- Reset asserted in HOLD -> m_valid=0 and s_ready=1 the next cycle. A following frame 8,8,8,8 with the macro undefined -> 8, 8, 4.
